// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: per-channel state
// encoding and a constant-evaluable ceiling-log2 used for width checks.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_PEND_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_PEND_LO   = 2'd3
  } deb_state_e;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input longint unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-FF synchroniser, symmetric press/release filter,
// debounced level, registered rise/fall pulses and a one-shot long-press pulse.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 250000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic hold_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  logic             sync1_q, sync2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             hold_q, hold_d;
  logic             enter_hi_s, enter_lo_s, high_side_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE_LO;
      cnt_q   <= CNT_ZERO;
      hcnt_q  <= CNT_ZERO;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STABLE_LO: begin
        if (sync2_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_STABLE_HI;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_PEND_HI;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_PEND_HI: begin
        if (!sync2_q) begin
          state_d = ST_STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!sync2_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_STABLE_LO;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_PEND_LO;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_PEND_LO: begin
        if (sync2_q) begin
          state_d = ST_STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE_LO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // A PEND_LO -> STABLE_HI bounce is not a new press, so only a crossing
  // from the low side counts as entering the high level.
  always_comb begin
    high_side_s = (state_q == ST_STABLE_HI) || (state_q == ST_PEND_LO);
    enter_hi_s  = (state_d == ST_STABLE_HI) && !high_side_s;
    enter_lo_s  = (state_d == ST_STABLE_LO) && high_side_s;
    hcnt_d      = hcnt_q;
    if (enter_hi_s || enter_lo_s) begin
      hcnt_d = CNT_ZERO;
    end else if (high_side_s && (hcnt_q != HOLD_MAX)) begin
      hcnt_d = hcnt_q + CNT_ONE;
    end else begin
      hcnt_d = hcnt_q;
    end
    level_d = (state_d == ST_STABLE_HI) || (state_d == ST_PEND_LO);
    rise_d  = enter_hi_s;
    fall_d  = enter_lo_s;
    hold_d  = (hcnt_d == HOLD_MAX) && (hcnt_q != HOLD_MAX);
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign hold_o  = hold_q;

endmodule

// File: rtl/multi_debouncer.sv
// N independent debouncer channels between board pins and control logic;
// every output is registered and synchronous to clk.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 250000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int CNT_W         = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] hold_pulse
);

  localparam longint unsigned MAX_CYCLES =
    (STABLE_CYCLES > HOLD_CYCLES) ? longint'(STABLE_CYCLES) : longint'(HOLD_CYCLES);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("multi_debouncer: STABLE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("multi_debouncer: HOLD_CYCLES must be >= 1");
  end
  if (CNT_W < clog2(MAX_CYCLES + 64'd1)) begin : g_bad_width
    $error("multi_debouncer: CNT_W too narrow for STABLE_CYCLES/HOLD_CYCLES");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .CNT_W         (CNT_W)
    ) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (raw_in[ch]),
      .level_o (level_out[ch]),
      .rise_o  (rise_pulse[ch]),
      .fall_o  (fall_pulse[ch]),
      .hold_o  (hold_pulse[ch])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: reference vector table, directed
// corner-case windows and randomized stimulus against a run-length model.
module tb_multi_debouncer;

  localparam int NCH = 2;
  localparam int SC  = 4;
  localparam int HC  = 10;
  localparam int CW  = 8;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_HOLD = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] level_out, rise_pulse, fall_pulse, hold_pulse;

  always #5 clk = ~clk;

  multi_debouncer #(
    .NUM_CH(NCH), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .level_out(level_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .hold_pulse(hold_pulse)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: sync pipeline, level flips after SC consecutive
  // disagreeing samples, hold fires HC cycles after a rise while level is high.
  bit [NCH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_hold;
  int m_run[NCH];
  int m_age[NCH];

  int first_ev[3][NCH];
  int cnt_ev[3][NCH];

  typedef struct {
    logic           rst;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] hold;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_rise = '0; m_fall = '0; m_hold = '0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0;
        m_age[c] = 0;
      end
    end else begin
      m_rise = '0; m_fall = '0; m_hold = '0;
      for (int c = 0; c < NCH; c++) begin
        if (m_s2[c] != m_lvl[c]) m_run[c] = m_run[c] + 1;
        else m_run[c] = 0;
        if (m_run[c] == SC) begin
          m_lvl[c]  = ~m_lvl[c];
          m_run[c]  = 0;
          m_age[c]  = 0;
          m_rise[c] = m_lvl[c];
          m_fall[c] = ~m_lvl[c];
        end else if (m_lvl[c] && m_age[c] < HC) begin
          m_age[c] = m_age[c] + 1;
          m_hold[c] = (m_age[c] == HC);
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
  endtask

  task automatic tick(input logic r, input logic [NCH-1:0] raw);
    @(negedge clk);
    rst_n  = r;
    raw_in = raw;
    @(posedge clk);
    model_step();
    #1;
    chk("model_level", 32'(level_out), 32'(m_lvl));
    chk("model_rise", 32'(rise_pulse), 32'(m_rise));
    chk("model_fall", 32'(fall_pulse), 32'(m_fall));
    chk("model_hold", 32'(hold_pulse), 32'(m_hold));
  endtask

  function automatic logic [NCH-1:0] ev_vec(input int w);
    if (w == EV_RISE) return rise_pulse;
    else if (w == EV_FALL) return fall_pulse;
    else return hold_pulse;
  endfunction

  // Apply raw for n cycles; record first offset and count of each pulse kind.
  task automatic run_window(input logic [NCH-1:0] raw, input int n);
    logic [NCH-1:0] v;
    for (int w = 0; w < 3; w++)
      for (int c = 0; c < NCH; c++) begin
        first_ev[w][c] = -1;
        cnt_ev[w][c]   = 0;
      end
    for (int i = 0; i < n; i++) begin
      tick(1'b1, raw);
      for (int w = 0; w < 3; w++) begin
        v = ev_vec(w);
        for (int c = 0; c < NCH; c++)
          if (v[c] === 1'b1) begin
            cnt_ev[w][c]++;
            if (first_ev[w][c] < 0) first_ev[w][c] = i;
          end
      end
    end
  endtask

  initial begin
    logic [NCH-1:0] rr;
    int dur[NCH];

    rst_n  = 1'b0;
    raw_in = '0;

    tbl[0]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[11] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[12] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};

    // Reset and clean press on channel 0.
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].rst, tbl[i].raw);
      chk($sformatf("tbl%0d_level", i), 32'(level_out),  32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_rise", i),  32'(rise_pulse), 32'(tbl[i].rise));
      chk($sformatf("tbl%0d_fall", i),  32'(fall_pulse), 32'(tbl[i].fall));
      chk($sformatf("tbl%0d_hold", i),  32'(hold_pulse), 32'(tbl[i].hold));
    end

    // Long press: rise was at tbl[10], window starts 3 cycles after it.
    run_window(2'b01, 10);
    chk("long_hold_at", first_ev[EV_HOLD][0], 7);
    chk("long_hold_once", cnt_ev[EV_HOLD][0], 1);
    run_window(2'b01, 6);
    chk("long_hold_saturated", cnt_ev[EV_HOLD][0], 0);
    run_window(2'b00, 8);
    chk("long_fall_at", first_ev[EV_FALL][0], 5);
    run_window(2'b01, 8);
    chk("repress_rise_at", first_ev[EV_RISE][0], 5);
    run_window(2'b01, 10);
    chk("repress_hold_at", first_ev[EV_HOLD][0], 7);
    run_window(2'b00, 8);
    chk("release_fall_at", first_ev[EV_FALL][0], 5);

    // Bounce with 3-cycle high periods never qualifies.
    for (int b = 0; b < 3; b++) begin
      run_window(2'b01, 3);
      chk("bounce_no_rise", cnt_ev[EV_RISE][0], 0);
      run_window(2'b00, 1);
      chk("bounce_no_fall", cnt_ev[EV_FALL][0], 0);
    end
    chk("bounce_level", 32'(level_out), 32'd0);
    run_window(2'b01, 8);
    chk("bounce_final_rise_at", first_ev[EV_RISE][0], 5);

    // Simultaneous channels, then ch1 falls while ch0 is holding.
    run_window(2'b00, 8);
    chk("sim_pre_fall_at", first_ev[EV_FALL][0], 5);
    run_window(2'b11, 8);
    chk("sim_rise0_at", first_ev[EV_RISE][0], 5);
    chk("sim_rise1_at", first_ev[EV_RISE][1], 5);
    chk("sim_rise1_once", cnt_ev[EV_RISE][1], 1);
    run_window(2'b01, 10);
    chk("sim_fall1_at", first_ev[EV_FALL][1], 5);
    chk("sim_hold0_at", first_ev[EV_HOLD][0], 7);
    chk("sim_no_hold1", cnt_ev[EV_HOLD][1], 0);
    chk("sim_no_fall0", cnt_ev[EV_FALL][0], 0);

    // Reset with ch1 at cnt=2 and ch0 at hcnt=7.
    run_window(2'b00, 8);
    run_window(2'b01, 9);
    chk("rst_pre_rise0_at", first_ev[EV_RISE][0], 5);
    run_window(2'b11, 4);
    chk("rst_pre_no_hold0", cnt_ev[EV_HOLD][0], 0);
    chk("rst_pre_no_rise1", cnt_ev[EV_RISE][1], 0);
    tick(1'b0, 2'b11);
    chk("rst_mid_level", 32'(level_out), 32'd0);
    chk("rst_mid_pulses", 32'(rise_pulse | fall_pulse | hold_pulse), 32'd0);
    run_window(2'b11, 8);
    chk("rst_post_rise0_at", first_ev[EV_RISE][0], 5);
    chk("rst_post_rise1_at", first_ev[EV_RISE][1], 5);
    chk("rst_post_no_fall", cnt_ev[EV_FALL][0] + cnt_ev[EV_FALL][1], 0);

    // Randomized bursts of bounce and steady periods, occasional reset.
    rr = raw_in;
    for (int c = 0; c < NCH; c++) dur[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (dur[c] == 0) begin
          rr[c] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) dur[c] = int'($urandom_range(5, 20));
          else dur[c] = int'($urandom_range(1, 4));
        end
        dur[c]--;
      end
      tick(($urandom_range(0, 299) != 0), rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
